// File: rtl/multicycle_ctrl_if.sv
// Sequencer <-> datapath/memory bundle: IR opcode and ALU flag in, datapath controls and memory strobes out.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0] i_opcode;
  logic       i_branch_taken;
  logic       i_mem_ready;
  logic       o_mem_req;
  logic       o_mem_we;
  logic       o_iord;
  logic       o_ir_write;
  logic       o_pc_write;
  logic       o_alu_src;
  logic       o_mem2reg;
  logic       o_reg_write;
  logic       o_branch;
  logic [1:0] o_alu_op;
  logic [2:0] o_state;
  logic       o_trap;

  modport master (
    input  i_opcode, i_branch_taken, i_mem_ready,
    output o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write,
    output o_alu_src, o_mem2reg, o_reg_write, o_branch, o_alu_op, o_state, o_trap
  );

  modport slave (
    output i_opcode, i_branch_taken, i_mem_ready,
    input  o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write,
    input  o_alu_src, o_mem2reg, o_reg_write, o_branch, o_alu_op, o_state, o_trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32-subset sequencer: 3-5 cycles per instruction, +1 per memory wait cycle.
// Stalls in FETCH/MEM until mem_ready; a wait of TIMEOUT cycles or an illegal opcode traps until reset.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IDLE   = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic       r_mem_req;
  logic       r_mem_we;
  logic       r_iord;
  logic       r_fetch;
  logic       r_alu_src;
  logic       r_mem2reg;
  logic       r_reg_write;
  logic       r_branch;
  logic [1:0] r_alu_op;
  logic       r_trap;

  logic w_is_r;
  logic w_is_load;
  logic w_is_store;
  logic w_is_br;
  logic w_legal;
  logic w_timeout;

  assign w_is_r     = (bus.i_opcode == OP_R);
  assign w_is_load  = (bus.i_opcode == OP_LOAD);
  assign w_is_store = (bus.i_opcode == OP_STORE);
  assign w_is_br    = (bus.i_opcode == OP_BR);
  assign w_legal    = w_is_r | w_is_load | w_is_store | w_is_br;
  // Only meaningful in FETCH/MEM; ready on the last allowed wait cycle wins.
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1)) && !bus.i_mem_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        if (bus.i_mem_ready)  w_next = S_DECODE;
        else if (w_timeout)   w_next = S_TRAP;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_is_r)                      w_next = S_WB;
        else if (w_is_load | w_is_store) w_next = S_MEM;
        else if (w_is_br)                w_next = S_FETCH;
        else                             w_next = S_TRAP;
      end
      S_MEM: begin
        if (bus.i_mem_ready)  w_next = w_is_store ? S_FETCH : S_WB;
        else if (w_timeout)   w_next = S_TRAP;
      end
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  // Outputs are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_iord      <= 1'b0;
      r_fetch     <= 1'b0;
      r_alu_src   <= 1'b0;
      r_mem2reg   <= 1'b0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_alu_op    <= 2'b00;
      r_trap      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_mem_req && !bus.i_mem_ready)
        r_cnt <= r_cnt + CNT_W'(1);

      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_iord      <= 1'b0;
      r_fetch     <= 1'b0;
      r_alu_src   <= 1'b0;
      r_mem2reg   <= 1'b0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_alu_op    <= 2'b00;
      r_trap      <= 1'b0;

      case (w_next)
        S_FETCH: begin
          r_mem_req <= 1'b1;
          r_fetch   <= 1'b1;
        end
        S_EXEC: begin
          if (w_is_r) begin
            r_alu_op <= 2'b10;
          end else if (w_is_load | w_is_store) begin
            r_alu_src <= 1'b1;
          end else if (w_is_br) begin
            r_alu_op <= 2'b01;
            r_branch <= 1'b1;
          end
        end
        S_MEM: begin
          r_mem_req <= 1'b1;
          r_iord    <= 1'b1;
          r_mem_we  <= w_is_store;
        end
        S_WB: begin
          r_reg_write <= 1'b1;
          r_mem2reg   <= w_is_load;
        end
        S_TRAP:  r_trap <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.o_state     = r_state;
  assign bus.o_mem_req   = r_mem_req;
  assign bus.o_mem_we    = r_mem_we;
  assign bus.o_iord      = r_iord;
  assign bus.o_ir_write  = r_fetch & bus.i_mem_ready;
  assign bus.o_pc_write  = (r_fetch & bus.i_mem_ready) | (r_branch & bus.i_branch_taken);
  assign bus.o_alu_src   = r_alu_src;
  assign bus.o_mem2reg   = r_mem2reg;
  assign bus.o_reg_write = r_reg_write;
  assign bus.o_branch    = r_branch;
  assign bus.o_alu_op    = r_alu_op;
  assign bus.o_trap      = r_trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed table, corner sequences, and random instruction streams
// checked against per-instruction expected traces built from the sequencing rules.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_BAD   = 7'b1100111;

  localparam logic [9:0] F_TRAP = 10'b10_0000_0000;
  localparam logic [9:0] F_MREQ = 10'b01_0000_0000;
  localparam logic [9:0] F_MWE  = 10'b00_1000_0000;
  localparam logic [9:0] F_IORD = 10'b00_0100_0000;
  localparam logic [9:0] F_IRW  = 10'b00_0010_0000;
  localparam logic [9:0] F_PCW  = 10'b00_0001_0000;
  localparam logic [9:0] F_ASRC = 10'b00_0000_1000;
  localparam logic [9:0] F_M2R  = 10'b00_0000_0100;
  localparam logic [9:0] F_RW   = 10'b00_0000_0010;
  localparam logic [9:0] F_BR   = 10'b00_0000_0001;

  typedef struct {
    logic        rdy;
    logic        tkn;
    logic [6:0]  op;
    logic [14:0] exp;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  cyc_t q[$];
  cyc_t vec[14];

  always #5 clk = ~clk;

  multicycle_ctrl_if bus_a ();
  multicycle_ctrl_if bus_b ();

  assign bus_a.i_opcode       = opcode;
  assign bus_a.i_branch_taken = branch_taken;
  assign bus_a.i_mem_ready    = mem_ready;
  assign bus_b.i_opcode       = opcode;
  assign bus_b.i_branch_taken = branch_taken;
  assign bus_b.i_mem_ready    = mem_ready;

  multicycle_ctrl u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_a),
    .bus     (bus_a)
  );

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(3)) u_dut_to (
    .i_clk   (clk),
    .i_rst_n (rst_b),
    .bus     (bus_b)
  );

  function automatic logic [14:0] pk(input logic [2:0] st, input logic [9:0] fl, input logic [1:0] aop);
    return {st, fl, aop};
  endfunction

  function automatic logic [14:0] obs(input int sel);
    if (sel == 0)
      return {bus_a.o_state, bus_a.o_trap, bus_a.o_mem_req, bus_a.o_mem_we, bus_a.o_iord,
              bus_a.o_ir_write, bus_a.o_pc_write, bus_a.o_alu_src, bus_a.o_mem2reg,
              bus_a.o_reg_write, bus_a.o_branch, bus_a.o_alu_op};
    else
      return {bus_b.o_state, bus_b.o_trap, bus_b.o_mem_req, bus_b.o_mem_we, bus_b.o_iord,
              bus_b.o_ir_write, bus_b.o_pc_write, bus_b.o_alu_src, bus_b.o_mem2reg,
              bus_b.o_reg_write, bus_b.o_branch, bus_b.o_alu_op};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BR);
  endfunction

  task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got state=%0d flags=%b aluop=%b, expected state=%0d flags=%b aluop=%b",
               nm, $time, act[14:12], act[11:2], act[1:0], exp[14:12], exp[11:2], exp[1:0]);
    end
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 0) rst_a = v;
    else          rst_b = v;
  endtask

  // Reset held for three cycles with ready/taken high, then one IDLE cycle after release.
  task automatic do_reset(input int sel);
    @(negedge clk);
    set_rst(sel, 1'b0);
    mem_ready = 1'b1;
    branch_taken = 1'b1;
    opcode = OP_R;
    repeat (3) begin
      #1 check("reset", obs(sel), pk(3'd5, 10'd0, 2'b00));
      @(negedge clk);
    end
    set_rst(sel, 1'b1);
    #1 check("idle", obs(sel), pk(3'd5, 10'd0, 2'b00));
  endtask

  task automatic push(input logic r, input logic t, input logic [6:0] o, input logic [14:0] e);
    cyc_t c;
    c.rdy = r; c.tkn = t; c.op = o; c.exp = e;
    q.push_back(c);
  endtask

  task automatic run_q(input int sel, input string nm);
    foreach (q[i]) begin
      @(negedge clk);
      mem_ready = q[i].rdy;
      branch_taken = q[i].tkn;
      opcode = q[i].op;
      #1 check(nm, obs(sel), q[i].exp);
    end
    q.delete();
  endtask

  task automatic push_trap(input logic [6:0] op, input int n);
    for (int i = 0; i < n; i++) push(rb(), rb(), op, pk(3'd7, F_TRAP, 2'b00));
  endtask

  // Expected cycle trace of one instruction: fw fetch waits, mw memory waits, tmo = timeout limit.
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input int tmo,
                           input int ntrap, output bit trapped);
    logic t;
    logic [9:0] mfl;
    trapped = 1'b0;
    for (int i = 0; i < fw && i < tmo; i++) push(1'b0, rb(), op, pk(3'd0, F_MREQ, 2'b00));
    if (fw >= tmo) begin
      push_trap(op, ntrap);
      trapped = 1'b1;
      return;
    end
    push(1'b1, rb(), op, pk(3'd0, F_MREQ | F_IRW | F_PCW, 2'b00));
    push(rb(), rb(), op, pk(3'd1, 10'd0, 2'b00));
    if (!is_legal(op)) begin
      push_trap(op, ntrap);
      trapped = 1'b1;
      return;
    end
    if (op == OP_R) begin
      push(rb(), rb(), op, pk(3'd2, 10'd0, 2'b10));
      push(rb(), rb(), op, pk(3'd4, F_RW, 2'b00));
    end else if (op == OP_BR) begin
      t = rb();
      push(rb(), t, op, pk(3'd2, F_BR | (t ? F_PCW : 10'd0), 2'b01));
    end else begin
      push(rb(), rb(), op, pk(3'd2, F_ASRC, 2'b00));
      mfl = F_MREQ | F_IORD | ((op == OP_STORE) ? F_MWE : 10'd0);
      for (int i = 0; i < mw && i < tmo; i++) push(1'b0, rb(), op, pk(3'd3, mfl, 2'b00));
      if (mw >= tmo) begin
        push_trap(op, ntrap);
        trapped = 1'b1;
        return;
      end
      push(1'b1, rb(), op, pk(3'd3, mfl, 2'b00));
      if (op == OP_LOAD) push(rb(), rb(), op, pk(3'd4, F_RW | F_M2R, 2'b00));
    end
  endtask

  initial begin
    bit tr;
    logic [6:0] op;
    int k, fw, mw, tmo;

    // R-type, STORE, BRANCH taken, BRANCH not taken, all zero-wait.
    vec[0]  = '{1'b1, 1'b0, OP_R,     pk(3'd0, F_MREQ | F_IRW | F_PCW, 2'b00)};
    vec[1]  = '{1'b1, 1'b0, OP_R,     pk(3'd1, 10'd0, 2'b00)};
    vec[2]  = '{1'b1, 1'b1, OP_R,     pk(3'd2, 10'd0, 2'b10)};
    vec[3]  = '{1'b1, 1'b0, OP_R,     pk(3'd4, F_RW, 2'b00)};
    vec[4]  = '{1'b1, 1'b0, OP_STORE, pk(3'd0, F_MREQ | F_IRW | F_PCW, 2'b00)};
    vec[5]  = '{1'b1, 1'b0, OP_STORE, pk(3'd1, 10'd0, 2'b00)};
    vec[6]  = '{1'b1, 1'b0, OP_STORE, pk(3'd2, F_ASRC, 2'b00)};
    vec[7]  = '{1'b1, 1'b0, OP_STORE, pk(3'd3, F_MREQ | F_MWE | F_IORD, 2'b00)};
    vec[8]  = '{1'b1, 1'b0, OP_BR,    pk(3'd0, F_MREQ | F_IRW | F_PCW, 2'b00)};
    vec[9]  = '{1'b1, 1'b0, OP_BR,    pk(3'd1, 10'd0, 2'b00)};
    vec[10] = '{1'b1, 1'b1, OP_BR,    pk(3'd2, F_BR | F_PCW, 2'b01)};
    vec[11] = '{1'b1, 1'b0, OP_BR,    pk(3'd0, F_MREQ | F_IRW | F_PCW, 2'b00)};
    vec[12] = '{1'b1, 1'b0, OP_BR,    pk(3'd1, 10'd0, 2'b00)};
    vec[13] = '{1'b1, 1'b0, OP_BR,    pk(3'd2, F_BR, 2'b01)};

    do_reset(0);
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      mem_ready = vec[i].rdy;
      branch_taken = vec[i].tkn;
      opcode = vec[i].op;
      #1 check($sformatf("vec%0d", i), obs(0), vec[i].exp);
    end
    q.delete();
    push(1'b0, 1'b0, OP_R, pk(3'd0, F_MREQ, 2'b00));
    run_q(0, "vec_refetch");

    // LOAD with two MEM wait cycles.
    do_reset(0);
    add_instr(OP_LOAD, 0, 2, 15, 0, tr);
    run_q(0, "load_wait");

    // Illegal opcode: trap held for 20 cycles.
    add_instr(OP_BAD, 1, 0, 15, 20, tr);
    run_q(0, "illegal");

    // TIMEOUT=4: fetch never ready -> trap after four wait cycles.
    do_reset(1);
    add_instr(OP_R, 100, 0, 4, 5, tr);
    run_q(1, "fetch_timeout");
    // Ready on the fourth wait cycle wins over timeout, in FETCH and in MEM.
    do_reset(1);
    add_instr(OP_R, 3, 0, 4, 0, tr);
    add_instr(OP_LOAD, 3, 3, 4, 0, tr);
    add_instr(OP_STORE, 0, 4, 4, 3, tr);
    run_q(1, "edge_timeout");

    // Reset asserted mid-way through a store wait.
    do_reset(0);
    push(1'b1, 1'b0, OP_STORE, pk(3'd0, F_MREQ | F_IRW | F_PCW, 2'b00));
    push(1'b0, 1'b0, OP_STORE, pk(3'd1, 10'd0, 2'b00));
    push(1'b0, 1'b0, OP_STORE, pk(3'd2, F_ASRC, 2'b00));
    push(1'b0, 1'b0, OP_STORE, pk(3'd3, F_MREQ | F_MWE | F_IORD, 2'b00));
    push(1'b0, 1'b0, OP_STORE, pk(3'd3, F_MREQ | F_MWE | F_IORD, 2'b00));
    run_q(0, "rst_mid_pre");
    @(negedge clk);
    #2 rst_a = 1'b0;
    #1 check("rst_mid_drop", obs(0), pk(3'd5, 10'd0, 2'b00));
    @(negedge clk);
    rst_a = 1'b1;
    #1 check("rst_mid_idle", obs(0), pk(3'd5, 10'd0, 2'b00));
    add_instr(OP_STORE, 0, 1, 15, 0, tr);
    run_q(0, "rst_mid_post");

    // Random instruction streams on both instances.
    for (int sel = 0; sel < 2; sel++) begin
      tmo = (sel == 0) ? 15 : 4;
      do_reset(sel);
      for (int n = 0; n < 40; n++) begin
        k = $urandom_range(0, 9);
        case (k)
          0, 9:    op = OP_R;
          1, 2:    op = OP_LOAD;
          3, 4:    op = OP_STORE;
          5, 6, 7: op = OP_BR;
          default: begin
            do op = 7'($urandom); while (is_legal(op));
          end
        endcase
        fw = ($urandom_range(0, 15) == 0) ? tmo + 1 : $urandom_range(0, 3);
        mw = ($urandom_range(0, 15) == 0) ? tmo + 1 : $urandom_range(0, 3);
        add_instr(op, fw, mw, tmo, 3, tr);
        run_q(sel, $sformatf("rand%0d_%0d", sel, n));
        if (tr) do_reset(sel);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
